// File: rtl/pixel_port_arbiter_if.sv
// pixel_port_arbiter_if: requester, RAM-port and read-return signals of the pixel port arbiter
interface pixel_port_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 24
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_blank;
  logic              disp_ack;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;
  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_ack;
  logic              ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  disp_req, disp_addr, disp_blank, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    output disp_ack, disp_rvalid, disp_rdata, ld_ack, ld_rvalid, ld_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output disp_req, disp_addr, disp_blank, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    input  disp_ack, disp_rvalid, disp_rdata, ld_ack, ld_rvalid, ld_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/pixel_port_arbiter.sv
// pixel_port_arbiter: shares one frame-memory port between display scan-out and a loader
module pixel_port_arbiter #(
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 24,
  parameter int STARVE_LIMIT = 8
) (
  input logic                  clk,
  input logic                  rst,
  pixel_port_arbiter_if.slave  bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {NONE, DISP, LD_RD} tag_e;
  logic [SW-1:0]     starve_q, starve_d;
  tag_e              tag1_q, tag1_d, tag2_q;
  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              ld_grant, disp_grant, starved;
  // grant selection: starved loader, then loader during blanking, then display, then idle loader
  always_comb begin
    starved    = starve_q == SW'(STARVE_LIMIT);
    ld_grant   = rst && bus.ld_req && (starved || bus.disp_blank || !bus.disp_req);
    disp_grant = rst && bus.disp_req && !ld_grant;
    starve_d   = ld_grant ? '0 : (bus.ld_req && !starved) ? starve_q + 1'b1 : starve_q;
    tag1_d     = disp_grant ? DISP : (ld_grant && !bus.ld_we) ? LD_RD : NONE;
  end
  // starvation counter, read-owner pipeline and registered RAM port
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_q    <= '0;
      tag1_q      <= NONE;
      tag2_q      <= NONE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      starve_q <= starve_d;
      tag1_q   <= tag1_d;
      tag2_q   <= tag1_q;
      mem_en_q <= ld_grant || disp_grant;
      mem_we_q <= ld_grant && bus.ld_we;
      if (ld_grant) begin
        mem_addr_q  <= bus.ld_addr;
        mem_wdata_q <= bus.ld_wdata;
      end else if (disp_grant) begin
        mem_addr_q <= bus.disp_addr;
      end
    end
  end
  assign bus.disp_ack    = disp_grant;
  assign bus.ld_ack      = ld_grant;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.disp_rvalid = tag2_q == DISP;
  assign bus.ld_rvalid   = tag2_q == LD_RD;
  assign bus.disp_rdata  = bus.disp_rvalid ? bus.mem_rdata : '0;
  assign bus.ld_rdata    = bus.ld_rvalid ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_pixel_port_arbiter.sv
// tb_pixel_port_arbiter: vector table, corner sequences and scoreboarded read returns
module tb_pixel_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  pixel_port_arbiter_if mif();
  pixel_port_arbiter dut (.clk(clk), .rst(rst), .bus(mif));

  int n_cmp = 0, n_err = 0, cyc = 0, rd_acks = 0, rv_cnt = 0;
  bit mon_on = 0;
  logic [23:0] ram  [logic [17:0]];
  logic [23:0] gold [logic [17:0]];
  logic [23:0] rd_q = '0;
  assign mif.mem_rdata = rd_q;

  typedef struct {logic is_ld; logic [23:0] data; int due;} exp_t;
  exp_t q[$];
  logic p_ack = 0, p_we = 0;
  logic [17:0] p_addr = '0;
  logic [23:0] p_wd = '0;

  function automatic logic [23:0] init_val(logic [17:0] a);
    return {a[5:0], a} ^ 24'h5A5A5A;
  endfunction
  function automatic logic [23:0] gold_rd(logic [17:0] a);
    return gold.exists(a) ? gold[a] : init_val(a);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // RAM model: data appears one cycle after a read strobe
  always @(posedge clk) begin
    if (mif.mem_en === 1'b1) begin
      if (mif.mem_we) ram[mif.mem_addr] = mif.mem_wdata;
      else rd_q <= ram.exists(mif.mem_addr) ? ram[mif.mem_addr] : init_val(mif.mem_addr);
    end
  end

  // monitor: exclusivity, RAM-port registration and scoreboarded read returns
  always @(negedge clk) begin
    cyc++;
    if (mon_on) begin
      chk("ack_mutex", mif.disp_ack && mif.ld_ack, 0);
      chk("rvalid_mutex", mif.disp_rvalid && mif.ld_rvalid, 0);
      while (q.size() > 0 && q[0].due < cyc) begin
        chk("rv_missing", cyc, q[0].due);
        q.delete(0);
      end
      if (mif.disp_rvalid || mif.ld_rvalid) begin
        rv_cnt++;
        if (q.size() == 0) chk("rv_unexpected", 1, 0);
        else begin
          chk("rv_due", cyc, q[0].due);
          chk("rv_owner", mif.ld_rvalid, q[0].is_ld);
          chk("rv_data", mif.ld_rvalid ? mif.ld_rdata : mif.disp_rdata, q[0].data);
          q.delete(0);
        end
      end else chk("rdata_idle", {mif.disp_rdata, mif.ld_rdata}, 0);
      chk("mem_en", mif.mem_en, p_ack);
      if (p_ack) begin
        chk("mem_we", mif.mem_we, p_we);
        chk("mem_addr", mif.mem_addr, p_addr);
        if (p_we) chk("mem_wdata", mif.mem_wdata, p_wd);
      end else chk("mem_we_idle", mif.mem_we, 0);
    end
    if (!rst) begin
      q.delete();
      p_ack = 0;
      p_we = 0;
    end else begin
      if (mif.disp_ack) begin
        q.push_back('{1'b0, gold_rd(mif.disp_addr), cyc + 2});
        rd_acks++;
      end
      if (mif.ld_ack && mif.ld_we) gold[mif.ld_addr] = mif.ld_wdata;
      else if (mif.ld_ack) begin
        q.push_back('{1'b1, gold_rd(mif.ld_addr), cyc + 2});
        rd_acks++;
      end
      p_ack  = mif.disp_ack || mif.ld_ack;
      p_we   = mif.ld_ack && mif.ld_we;
      p_addr = mif.ld_ack ? mif.ld_addr : mif.disp_addr;
      p_wd   = mif.ld_wdata;
    end
  end

  typedef struct {logic d, b, l; logic ed, el;} vec_t;
  vec_t vt[8];

  task automatic idle_reqs;
    mif.disp_req = 0;
    mif.ld_req = 0;
    mif.ld_we = 0;
    mif.disp_blank = 0;
  endtask

  task automatic drain(int n);
    idle_reqs();
    repeat (n) tick();
  endtask

  task automatic do_reset;
    idle_reqs();
    rst = 0;
    tick();
    rst = 1;
  endtask

  initial begin
    logic da, la;
    int a0, r0;
    mif.disp_addr = '0;
    mif.ld_addr = '0;
    mif.ld_wdata = '0;
    idle_reqs();
    mif.disp_req = 1;
    mif.ld_req = 1;
    rst = 0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_disp_ack", mif.disp_ack, 0);
    chk("rst_ld_ack", mif.ld_ack, 0);
    chk("rst_mem", {mif.mem_en, mif.mem_we, mif.mem_addr, mif.mem_wdata}, 0);
    chk("rst_rvalid", {mif.disp_rvalid, mif.ld_rvalid}, 0);
    chk("rst_rdata", {mif.disp_rdata, mif.ld_rdata}, 0);
    idle_reqs();
    tick();
    rst = 1;
    mon_on = 1;
    // arbitration priority vectors from zero starvation count
    vt[0] = '{0, 0, 0, 0, 0};
    vt[1] = '{1, 0, 0, 1, 0};
    vt[2] = '{0, 0, 1, 0, 1};
    vt[3] = '{1, 1, 1, 0, 1};
    vt[4] = '{1, 0, 1, 1, 0};
    vt[5] = '{1, 1, 0, 1, 0};
    vt[6] = '{0, 1, 1, 0, 1};
    vt[7] = '{0, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      mif.disp_req = vt[i].d;
      mif.disp_blank = vt[i].b;
      mif.ld_req = vt[i].l;
      mif.ld_we = 0;
      mif.disp_addr = 18'(i + 32);
      mif.ld_addr = 18'(i + 64);
      @(negedge clk);
      chk("vec_disp_ack", mif.disp_ack, vt[i].ed);
      chk("vec_ld_ack", mif.ld_ack, vt[i].el);
      tick();
    end
    drain(3);
    // display-only burst at 0x10..0x13
    for (int j = 0; j < 7; j++) begin
      mif.disp_req = j < 4;
      mif.disp_addr = 18'(16 + j);
      @(negedge clk);
      chk("burst_ack", mif.disp_ack, j < 4);
      chk("burst_mem_en", mif.mem_en, j >= 1 && j <= 4);
      chk("burst_rvalid", mif.disp_rvalid, j >= 2 && j <= 5);
      tick();
    end
    drain(2);
    // sustained contention without blanking
    do_reset();
    mif.disp_req = 1;
    mif.ld_req = 1;
    mif.disp_addr = 18'h00100;
    mif.ld_addr = 18'h00200;
    for (int j = 0; j < 27; j++) begin
      @(negedge clk);
      chk("cont_ld_ack", mif.ld_ack, j % 9 == 8);
      chk("cont_disp_ack", mif.disp_ack, j % 9 != 8);
      if (j % 9 == 0 && j > 0) chk("cont_starve_clr", dut.starve_q, 0);
      tick();
    end
    drain(3);
    // blanking gives the loader every cycle, falling edge returns the port at once
    mif.disp_req = 1;
    mif.ld_req = 1;
    mif.disp_blank = 1;
    for (int j = 0; j < 4; j++) begin
      mif.disp_blank = j < 3;
      @(negedge clk);
      chk("blank_ld_ack", mif.ld_ack, j < 3);
      chk("blank_disp_ack", mif.disp_ack, j == 3);
      tick();
    end
    drain(3);
    // loader write then read-back at the top address
    mif.ld_req = 1;
    mif.ld_we = 1;
    mif.ld_addr = 18'h3FFFF;
    mif.ld_wdata = 24'hFF00AA;
    @(negedge clk);
    chk("wr_ack", mif.ld_ack, 1);
    tick();
    mif.ld_we = 0;
    @(negedge clk);
    chk("rd_ack", mif.ld_ack, 1);
    chk("wr_mem_we", mif.mem_we, 1);
    chk("wr_mem_addr", mif.mem_addr, 18'h3FFFF);
    chk("wr_mem_wdata", mif.mem_wdata, 24'hFF00AA);
    tick();
    mif.ld_req = 0;
    @(negedge clk);
    chk("rd_mem_we", mif.mem_we, 0);
    chk("wr_no_rvalid", mif.ld_rvalid, 0);
    tick();
    @(negedge clk);
    chk("rd_rvalid", mif.ld_rvalid, 1);
    chk("rd_rdata", mif.ld_rdata, 24'hFF00AA);
    tick();
    drain(2);
    // reset pulse right behind a display read ack
    mif.disp_req = 1;
    mif.disp_addr = 18'h00055;
    @(negedge clk);
    chk("rstmid_ack", mif.disp_ack, 1);
    tick();
    mif.disp_req = 0;
    rst = 0;
    tick();
    rst = 1;
    @(negedge clk);
    chk("rstmid_mem_en", mif.mem_en, 0);
    chk("rstmid_rvalid0", mif.disp_rvalid, 0);
    tick();
    @(negedge clk);
    chk("rstmid_rvalid1", mif.disp_rvalid, 0);
    tick();
    // random traffic with requests held until acked
    a0 = rd_acks;
    r0 = rv_cnt;
    da = 0;
    la = 0;
    for (int n = 0; n < 400; n++) begin
      if (!mif.disp_req || da) begin
        mif.disp_req = 1'($urandom_range(0, 1));
        mif.disp_addr = 18'($urandom_range(0, 15));
      end
      if (!mif.ld_req || la) begin
        mif.ld_req = 1'($urandom_range(0, 1));
        mif.ld_we = 1'($urandom_range(0, 1));
        mif.ld_addr = 18'($urandom_range(0, 15));
        mif.ld_wdata = 24'($urandom);
      end
      mif.disp_blank = $urandom_range(0, 3) == 0;
      @(negedge clk);
      da = mif.disp_ack;
      la = mif.ld_ack;
      tick();
    end
    drain(4);
    chk("rand_read_count", rv_cnt - r0, rd_acks - a0);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pixel_port_arbiter.md
PIXEL_PORT_ARBITER -- requirements
Module: pixel_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 18, meaning the frame-memory word address width.
REQ-002 The block SHALL have parameter DATA_W, default 24, meaning the RGB pixel word width.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 8, meaning the number of consecutive denied loader cycles before the loader is forced a grant.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset.
REQ-005 clk  in  1  system clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-low reset.
REQ-007 disp_req  in  1  display scan-out read request.
REQ-008 disp_addr  in  ADDR_W  display read address.
REQ-009 disp_blank  in  1  display in blanking, so the loader takes priority.
REQ-010 disp_ack  out  1  display request accepted this cycle.
REQ-011 disp_rvalid  out  1  display read data valid.
REQ-012 disp_rdata  out  DATA_W  display read data.
REQ-013 ld_req  in  1  loader request.
REQ-014 ld_we  in  1  loader write, where 1 means write and 0 means read.
REQ-015 ld_addr  in  ADDR_W  loader address.
REQ-016 ld_wdata  in  DATA_W  loader write data.
REQ-017 ld_ack  out  1  loader request accepted this cycle.
REQ-018 ld_rvalid  out  1  loader read data valid.
REQ-019 ld_rdata  out  DATA_W  loader read data.
REQ-020 mem_en  out  1  RAM port access strobe.
REQ-021 mem_we  out  1  RAM port write strobe.
REQ-022 mem_addr  out  ADDR_W  RAM port address.
REQ-023 mem_wdata  out  DATA_W  RAM port write data.
REQ-024 mem_rdata  in  DATA_W  RAM port read data, valid one cycle after the access strobe.

Function
REQ-025 Each requester SHALL hold req, address, we and wdata stable until its ack, and the block SHALL not require req to drop after ack, since back-to-back accepted requests every cycle are legal.
REQ-026 Arbitration SHALL be combinational in cycle N, and at most one of disp_ack and ld_ack SHALL be high in any cycle.
REQ-027 Grant priority SHALL be, in order: (a) loader if ld_req and starve_cnt==STARVE_LIMIT; (b) loader if ld_req and disp_blank; (c) display if disp_req; (d) loader if ld_req; (e) none.
REQ-028 starve_cnt SHALL be ceil(log2(STARVE_LIMIT+1)) bits wide, increment on cycles with ld_req and no ld_ack, saturate at STARVE_LIMIT, and clear on ld_ack.
REQ-029 On an ack in cycle N, the block SHALL register mem_en=1, mem_addr, mem_we (1 only for a loader write) and mem_wdata, driving them in cycle N+1.
REQ-030 With no ack in cycle N, mem_en and mem_we SHALL be 0 in cycle N+1, and mem_addr and mem_wdata SHALL hold their previous values.
REQ-031 A two-stage owner-tag pipeline (tag values NONE, DISP, LD_RD) SHALL track each accepted read, and a loader write SHALL enter the pipeline as NONE.
REQ-032 A read acked in cycle N SHALL assert the owner's rvalid in cycle N+2, with the owner's rdata equal to mem_rdata in that cycle.
REQ-033 Read latency SHALL be exactly 2 cycles from ack to rvalid, and return order SHALL equal grant order.
REQ-034 disp_rdata SHALL be 0 when disp_rvalid=0, and ld_rdata SHALL be 0 when ld_rvalid=0.
REQ-035 disp_rvalid and ld_rvalid SHALL never be high in the same cycle.
REQ-036 A loader request arriving in the same cycle that disp_blank falls SHALL be arbitrated using the disp_blank value present in that cycle.
REQ-037 The forced loader grant of REQ-027(a) SHALL override a simultaneous display request even when disp_blank=0.
REQ-038 A pixel display request denied in favour of the loader SHALL be retried, and the block SHALL not drop it.

Reset
REQ-039 While rst=0 at a clock edge, the block SHALL set starve_cnt=0, clear both tag stages to NONE, and set mem_en=0, mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-040 During rst=0, disp_ack and ld_ack SHALL be 0.
REQ-041 After reset, disp_rvalid, ld_rvalid, disp_rdata and ld_rdata SHALL be 0.
REQ-042 Reads in flight when reset is asserted SHALL be discarded, so that no rvalid appears in the two cycles after reset release unless the read was acked after that release.

Verification
REQ-043 The bench SHALL cover: display-only, disp_req held for 4 cycles at addresses 0x00010-0x00013 -> disp_ack in every cycle, mem_en high for 4 cycles starting one cycle later, and disp_rvalid high for 4 cycles starting 2 cycles after the first ack with rdata matching the RAM model.
REQ-044 The bench SHALL cover: contention with disp_blank=0, where disp_req and ld_req are held continuously -> ld_ack exactly once every STARVE_LIMIT+1=9 cycles, display acks on all other cycles, and starve_cnt returning to 0 after each loader grant.
REQ-045 The bench SHALL cover: blanking, where disp_blank=1 with both requesting -> ld_ack every cycle and no disp_ack; then disp_blank falls -> disp_ack in that same cycle.
REQ-046 The bench SHALL cover: loader write of 0xFF00AA to address 0x3FFFF, followed by a loader read of the same address -> mem_we high for exactly one cycle, no ld_rvalid for the write, then ld_rvalid with ld_rdata=0xFF00AA 2 cycles after the read ack.
REQ-047 The bench SHALL cover: reset mid-operation, where rst is pulsed low in the cycle after a display read ack -> disp_rvalid stays 0, and mem_en=0 in the cycle following the reset edge.
REQ-048 The bench SHALL cover: the mutual-exclusion property under random stimulus -> disp_ack and ld_ack are never both high, disp_rvalid and ld_rvalid are never both high, and the count of rvalid pulses equals the count of acked reads.
